// File: rtl/nfa_report_pkg.sv
// Shared types for the NFA match reporter: batch record, serializer states, width defaults.
package nfa_report_pkg;

  localparam int NUM_ENGINES = 32;
  localparam int OFFSET_W    = 16;
  localparam int ID_W        = $clog2(NUM_ENGINES);

  typedef struct packed {
    logic [NUM_ENGINES-1:0] mask;
    logic [OFFSET_W-1:0]    off;
  } batch_t;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } ser_state_t;

endpackage

// File: rtl/nfa_batch_fifo.sv
// Synchronous FIFO of match batches; a pop in the same cycle makes room for a push into a full FIFO.
module nfa_batch_fifo
  import nfa_report_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  batch_t wr_data,
  input  logic   pop,
  output batch_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;
  batch_t      mem_q [DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/nfa_match_reporter.sv
// Detects each engine's first match per stream and serializes (engine id, byte offset) events.
module nfa_match_reporter #(
  parameter int NUM_ENGINES = nfa_report_pkg::NUM_ENGINES,
  parameter int OFFSET_W    = nfa_report_pkg::OFFSET_W,
  parameter int FIFO_DEPTH  = 8,
  parameter int ID_W        = $clog2(NUM_ENGINES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sod,
  input  logic                   en,
  input  logic [NUM_ENGINES-1:0] eng_out,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [ID_W-1:0]        evt_id,
  output logic [OFFSET_W-1:0]    evt_offset,
  output logic                   overflow
);

  import nfa_report_pkg::*;

  logic [OFFSET_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [NUM_ENGINES-1:0] seen_q, seen_d;
  logic [NUM_ENGINES-1:0] wmask_q, wmask_d;
  logic [OFFSET_W-1:0]    woff_q, woff_d;
  logic                   overflow_q, overflow_d;
  ser_state_t             state_q, state_d;

  logic [NUM_ENGINES-1:0] new_mask, rem_mask, id_onehot;
  logic [ID_W-1:0]        low_id;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  batch_t                 fifo_wr, fifo_rd;

  // The engines register their outputs, so a rise names the byte before the current count.
  always_comb begin
    new_mask      = eng_out & ~seen_q;
    fifo_push     = |new_mask;
    fifo_wr.mask  = new_mask;
    fifo_wr.off   = byte_cnt_q - OFFSET_W'(1);
    seen_d        = sod ? '0 : (seen_q | new_mask);
    byte_cnt_d    = byte_cnt_q;
    if (sod)                       byte_cnt_d = '0;
    else if (en && ~&byte_cnt_q)   byte_cnt_d = byte_cnt_q + OFFSET_W'(1);
    overflow_d    = sod ? 1'b0 : (overflow_q | (fifo_push & fifo_full & ~fifo_pop));
  end

  always_comb begin
    low_id = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (wmask_q[i]) low_id = ID_W'(i);
    end
  end

  // Refilling from the FIFO on the last handshake of a batch keeps back-to-back events bubble-free.
  always_comb begin
    state_d   = state_q;
    wmask_d   = wmask_q;
    woff_d    = woff_q;
    fifo_pop  = 1'b0;
    id_onehot = {{(NUM_ENGINES-1){1'b0}}, 1'b1} << low_id;
    rem_mask  = wmask_q & ~id_onehot;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          wmask_d  = fifo_rd.mask;
          woff_d   = fifo_rd.off;
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        if (evt_ready) begin
          wmask_d = rem_mask;
          if (rem_mask == '0) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              wmask_d  = fifo_rd.mask;
              woff_d   = fifo_rd.off;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      seen_q     <= '0;
      wmask_q    <= '0;
      woff_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      seen_q     <= seen_d;
      wmask_q    <= wmask_d;
      woff_q     <= woff_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  assign evt_valid  = (state_q == S_EMIT);
  assign evt_id     = low_id;
  assign evt_offset = woff_q;
  assign overflow   = overflow_q;

  nfa_batch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push),
    .wr_data(fifo_wr),
    .pop    (fifo_pop),
    .rd_data(fifo_rd),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule
